// File: rtl/nx1_mgarb_pkg.sv
// Shared definitions for the mem-side buffer port arbiter.
// Instruction bit positions, FSM state codes and port limits.
package nx1_mgarb_pkg;

  localparam int INSTR_RD     = 0;
  localparam int INSTR_NODATA = 2;
  localparam int NPORT_MAX    = 8;
  localparam int GW           = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WDATA,
    ST_RDATA
  } state_t;

endpackage

// File: rtl/nx1_mgarb_rrsel.sv
// Round-robin winner select with optional absolute priority for port 0.
// Scans upward from the port after the last grant, wrapping at NPORT.
module nx1_mgarb_rrsel
  import nx1_mgarb_pkg::*;
#(
  parameter int NPORT = 6,
  parameter bit PRIO0 = 1'b0
) (
  input  logic [NPORT-1:0] i_req,
  input  logic [GW-1:0]    i_last,
  output logic [GW-1:0]    o_win,
  output logic             o_vld
);

  logic [NPORT_MAX-1:0] w_req8;
  logic [GW:0]          w_idx;

  assign w_req8 = NPORT_MAX'(i_req);

  // Descending scan: the last hit written is the nearest one after i_last.
  always_comb begin
    o_win = '0;
    o_vld = 1'b0;
    w_idx = '0;
    if (PRIO0 && i_req[0]) begin
      o_win = '0;
      o_vld = 1'b1;
    end else begin
      for (int k = NPORT; k >= 1; k--) begin
        w_idx = {1'b0, i_last} + (GW+1)'(k);
        if (w_idx >= (GW+1)'(NPORT))
          w_idx = w_idx - (GW+1)'(NPORT);
        if (w_req8[w_idx[GW-1:0]]) begin
          o_win = w_idx[GW-1:0];
          o_vld = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/nx1_mgarb.sv
// Shares one cellular-RAM controller port among NPORT buffer ports.
// Grant is held from command issue until the last data beat.
module nx1_mgarb
  import nx1_mgarb_pkg::*;
#(
  parameter int NPORT = 6,
  parameter bit PRIO0 = 1'b0
) (
  input  logic                mem_clk,
  input  logic                mem_rst_n,
  input  logic [NPORT-1:0]    m_cmd_req,
  input  logic [3*NPORT-1:0]  m_cmd_instr,
  input  logic [6*NPORT-1:0]  m_cmd_bl,
  input  logic [30*NPORT-1:0] m_cmd_byte_addr,
  output logic [NPORT-1:0]    m_cmd_ack,
  input  logic [4*NPORT-1:0]  m_wr_mask,
  input  logic [32*NPORT-1:0] m_wr_data,
  output logic [NPORT-1:0]    m_wr_ack,
  output logic [NPORT-1:0]    m_rd_req,
  output logic [31:0]         m_rd_data,
  output logic                s_cmd_req,
  output logic [2:0]          s_cmd_instr,
  output logic [5:0]          s_cmd_bl,
  output logic [29:0]         s_cmd_byte_addr,
  input  logic                s_cmd_ack,
  output logic [3:0]          s_wr_mask,
  output logic [31:0]         s_wr_data,
  input  logic                s_wr_ack,
  input  logic                s_rd_req,
  input  logic [31:0]         s_rd_data,
  output logic                busy,
  output logic [2:0]          grant,
  output logic                stray_err
);

  state_t        r_state;
  logic [5:0]    r_cnt;
  logic [GW-1:0] r_grant;
  logic          r_cmd_req;
  logic [2:0]    r_instr;
  logic [5:0]    r_bl;
  logic [29:0]   r_addr;
  logic          r_stray;

  logic [GW-1:0] w_win;
  logic          w_vld;
  logic [2:0]    w_sel_instr;
  logic [5:0]    w_sel_bl;
  logic [29:0]   w_sel_addr;
  logic          w_in_issue;
  logic          w_in_wdata;
  logic          w_in_rdata;
  logic          w_stray;

  nx1_mgarb_rrsel #(
    .NPORT (NPORT),
    .PRIO0 (PRIO0)
  ) u_rrsel (
    .i_req  (m_cmd_req),
    .i_last (r_grant),
    .o_win  (w_win),
    .o_vld  (w_vld)
  );

  assign w_in_issue = (r_state == ST_ISSUE);
  assign w_in_wdata = (r_state == ST_WDATA);
  assign w_in_rdata = (r_state == ST_RDATA);
  assign w_stray    = (s_wr_ack && !w_in_wdata) ||
                      (s_rd_req && !w_in_rdata);

  always_comb begin
    w_sel_instr = '0;
    w_sel_bl    = '0;
    w_sel_addr  = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (GW'(i) == w_win) begin
        w_sel_instr = m_cmd_instr[3*i +: 3];
        w_sel_bl    = m_cmd_bl[6*i +: 6];
        w_sel_addr  = m_cmd_byte_addr[30*i +: 30];
      end
    end
  end

  always_comb begin
    m_cmd_ack = '0;
    m_wr_ack  = '0;
    m_rd_req  = '0;
    s_wr_mask = '0;
    s_wr_data = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (GW'(i) == r_grant) begin
        m_cmd_ack[i] = w_in_issue && s_cmd_ack;
        m_wr_ack[i]  = w_in_wdata && s_wr_ack;
        m_rd_req[i]  = w_in_rdata && s_rd_req;
        s_wr_mask    = m_wr_mask[4*i +: 4];
        s_wr_data    = m_wr_data[32*i +: 32];
      end
    end
  end

  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_grant   <= GW'(NPORT-1);
      r_cmd_req <= 1'b0;
      r_instr   <= '0;
      r_bl      <= '0;
      r_addr    <= '0;
      r_stray   <= 1'b0;
    end else begin
      if (w_stray)
        r_stray <= 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          if (w_vld) begin
            r_instr   <= w_sel_instr;
            r_bl      <= w_sel_bl;
            r_addr    <= w_sel_addr;
            r_grant   <= w_win;
            r_cmd_req <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (s_cmd_ack) begin
            r_cmd_req <= 1'b0;
            r_cnt     <= r_bl;
            if (r_instr[INSTR_NODATA])
              r_state <= ST_IDLE;
            else if (r_instr[INSTR_RD])
              r_state <= ST_RDATA;
            else
              r_state <= ST_WDATA;
          end
        end
        ST_WDATA: begin
          if (s_wr_ack) begin
            if (r_cnt == '0)
              r_state <= ST_IDLE;
            else
              r_cnt <= r_cnt - 6'd1;
          end
        end
        ST_RDATA: begin
          if (s_rd_req) begin
            if (r_cnt == '0)
              r_state <= ST_IDLE;
            else
              r_cnt <= r_cnt - 6'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_cmd_req       = r_cmd_req;
  assign s_cmd_instr     = r_instr;
  assign s_cmd_bl        = r_bl;
  assign s_cmd_byte_addr = r_addr;
  assign m_rd_data       = s_rd_data;
  assign busy            = (r_state != ST_IDLE);
  assign grant           = r_grant;
  assign stray_err       = r_stray;

endmodule

// File: tb/tb_nx1_mgarb.sv
// Directed bench for nx1_mgarb: round-robin and port-0-priority builds.
// Expected values are hand-derived constants.
module tb_nx1_mgarb;

  localparam int NP = 6;

  logic          clk;
  logic          rst_n;
  logic [NP-1:0] req;
  logic [NP-1:0] p_req;
  logic [3*NP-1:0]  instr;
  logic [6*NP-1:0]  bl;
  logic [30*NP-1:0] addr;
  logic [4*NP-1:0]  wmask;
  logic [32*NP-1:0] wdata;
  logic          cack;
  logic          p_cack;
  logic          wack;
  logic          rreq;
  logic [31:0]   rdata;

  logic [NP-1:0] m_cmd_ack, m_wr_ack, m_rd_req;
  logic [31:0]   m_rd_data;
  logic          s_cmd_req;
  logic [2:0]    s_cmd_instr;
  logic [5:0]    s_cmd_bl;
  logic [29:0]   s_cmd_addr;
  logic [3:0]    s_wr_mask;
  logic [31:0]   s_wr_data;
  logic          busy, stray_err;
  logic [2:0]    grant;

  logic [NP-1:0] p_m_cmd_ack, p_m_wr_ack, p_m_rd_req;
  logic [31:0]   p_m_rd_data;
  logic          p_s_cmd_req;
  logic [2:0]    p_s_cmd_instr;
  logic [5:0]    p_s_cmd_bl;
  logic [29:0]   p_s_cmd_addr;
  logic [3:0]    p_s_wr_mask;
  logic [31:0]   p_s_wr_data;
  logic          p_busy, p_stray_err;
  logic [2:0]    p_grant;

  int n_vec;
  int n_bad;

  nx1_mgarb #(.NPORT(NP), .PRIO0(1'b0)) u_dut (
    .mem_clk         (clk),
    .mem_rst_n       (rst_n),
    .m_cmd_req       (req),
    .m_cmd_instr     (instr),
    .m_cmd_bl        (bl),
    .m_cmd_byte_addr (addr),
    .m_cmd_ack       (m_cmd_ack),
    .m_wr_mask       (wmask),
    .m_wr_data       (wdata),
    .m_wr_ack        (m_wr_ack),
    .m_rd_req        (m_rd_req),
    .m_rd_data       (m_rd_data),
    .s_cmd_req       (s_cmd_req),
    .s_cmd_instr     (s_cmd_instr),
    .s_cmd_bl        (s_cmd_bl),
    .s_cmd_byte_addr (s_cmd_addr),
    .s_cmd_ack       (cack),
    .s_wr_mask       (s_wr_mask),
    .s_wr_data       (s_wr_data),
    .s_wr_ack        (wack),
    .s_rd_req        (rreq),
    .s_rd_data       (rdata),
    .busy            (busy),
    .grant           (grant),
    .stray_err       (stray_err)
  );

  nx1_mgarb #(.NPORT(NP), .PRIO0(1'b1)) u_dut_p0 (
    .mem_clk         (clk),
    .mem_rst_n       (rst_n),
    .m_cmd_req       (p_req),
    .m_cmd_instr     (instr),
    .m_cmd_bl        (bl),
    .m_cmd_byte_addr (addr),
    .m_cmd_ack       (p_m_cmd_ack),
    .m_wr_mask       (wmask),
    .m_wr_data       (wdata),
    .m_wr_ack        (p_m_wr_ack),
    .m_rd_req        (p_m_rd_req),
    .m_rd_data       (p_m_rd_data),
    .s_cmd_req       (p_s_cmd_req),
    .s_cmd_instr     (p_s_cmd_instr),
    .s_cmd_bl        (p_s_cmd_bl),
    .s_cmd_byte_addr (p_s_cmd_addr),
    .s_cmd_ack       (p_cack),
    .s_wr_mask       (p_s_wr_mask),
    .s_wr_data       (p_s_wr_data),
    .s_wr_ack        (wack),
    .s_rd_req        (rreq),
    .s_rd_data       (rdata),
    .busy            (p_busy),
    .grant           (p_grant),
    .stray_err       (p_stray_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req   = '0;
    p_req = '0;
    instr = '0;
    bl    = '0;
    addr  = '0;
    wmask = '0;
    wdata = '0;
    cack  = 1'b0;
    p_cack = 1'b0;
    wack  = 1'b0;
    rreq  = 1'b0;
    rdata = '0;
    for (int i = 0; i < NP; i++) begin
      wdata[32*i +: 32] = 32'hA000_0000 + 32'(i);
      wmask[4*i +: 4]   = 4'(i + 1);
    end
    tick();
    chk("rst_grant", 64'(grant), 64'd5);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cmdreq", 64'(s_cmd_req), 64'd0);
    chk("rst_addr", 64'(s_cmd_addr), 64'd0);
    chk("rst_stray", 64'(stray_err), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: single 4-beat write from port 2
    instr[3*2 +: 3]  = 3'b000;
    bl[6*2 +: 6]     = 6'd3;
    addr[30*2 +: 30] = 30'h100;
    req[2] = 1'b1;
    chk("w_pre_req", 64'(s_cmd_req), 64'd0);
    tick();
    chk("w_cmdreq", 64'(s_cmd_req), 64'd1);
    chk("w_addr", 64'(s_cmd_addr), 64'h100);
    chk("w_bl", 64'(s_cmd_bl), 64'd3);
    chk("w_grant", 64'(grant), 64'd2);
    cack = 1'b1;
    #1;
    chk("w_cmdack", 64'(m_cmd_ack), 64'b000100);
    tick();
    cack = 1'b0;
    req[2] = 1'b0;
    chk("w_cmdreq_low", 64'(s_cmd_req), 64'd0);
    chk("w_data", 64'(s_wr_data), 64'hA000_0002);
    chk("w_mask", 64'(s_wr_mask), 64'd3);
    for (int b = 0; b < 4; b++) begin
      chk("w_busy", 64'(busy), 64'd1);
      wack = 1'b1;
      #1;
      chk("w_wrack", 64'(m_wr_ack), 64'b000100);
      tick();
      wack = 1'b0;
    end
    chk("w_done_busy", 64'(busy), 64'd0);

    // 2: single-beat read on port 0
    instr[0 +: 3]  = 3'b001;
    bl[0 +: 6]     = 6'd0;
    addr[0 +: 30]  = 30'h55;
    req[0] = 1'b1;
    tick();
    chk("r_grant", 64'(grant), 64'd0);
    chk("r_instr", 64'(s_cmd_instr), 64'd1);
    cack = 1'b1;
    #1;
    chk("r_cmdack", 64'(m_cmd_ack), 64'b000001);
    tick();
    cack = 1'b0;
    req[0] = 1'b0;
    rreq  = 1'b1;
    rdata = 32'hDEAD_BEEF;
    #1;
    chk("r_rdreq", 64'(m_rd_req), 64'b000001);
    chk("r_rddata", 64'(m_rd_data), 64'hDEAD_BEEF);
    tick();
    rreq = 1'b0;
    chk("r_done_busy", 64'(busy), 64'd0);
    chk("r_no_stray", 64'(stray_err), 64'd0);

    // 3: round robin among 1,3,5 with refresh commands
    for (int i = 0; i < NP; i++)
      instr[3*i +: 3] = 3'b100;
    req = 6'b101010;
    for (int n = 0; n < 6; n++) begin
      logic [2:0] exp_g;
      exp_g = (n % 3 == 0) ? 3'd1 : ((n % 3 == 1) ? 3'd3 : 3'd5);
      tick();
      chk("rr_cmdreq", 64'(s_cmd_req), 64'd1);
      chk("rr_grant", 64'(grant), 64'(exp_g));
      cack = 1'b1;
      tick();
      cack = 1'b0;
      // 4: refresh goes straight back to idle
      chk("ref_idle", 64'(busy), 64'd0);
    end
    req = '0;
    chk("ref_no_stray", 64'(stray_err), 64'd0);

    // port-0 priority build: port 0 wins while requesting
    p_req = 6'b000011;
    for (int n = 0; n < 4; n++) begin
      if (n == 3)
        p_req = 6'b000010;
      tick();
      chk("p0_cmdreq", 64'(p_s_cmd_req), 64'd1);
      chk("p0_grant", 64'(p_grant), (n == 3) ? 64'd1 : 64'd0);
      p_cack = 1'b1;
      tick();
      p_cack = 1'b0;
    end
    p_req = '0;
    tick();

    // 5: stray strobes in idle
    rreq = 1'b1;
    wack = 1'b1;
    #1;
    chk("st_rdreq", 64'(m_rd_req), 64'd0);
    chk("st_wrack", 64'(m_wr_ack), 64'd0);
    tick();
    rreq = 1'b0;
    wack = 1'b0;
    chk("st_err", 64'(stray_err), 64'd1);
    tick();
    tick();
    chk("st_sticky", 64'(stray_err), 64'd1);

    // 6: reset mid-write after 2 of 8 beats
    instr[3*3 +: 3] = 3'b000;
    bl[6*3 +: 6]    = 6'd7;
    req[3] = 1'b1;
    tick();
    chk("rs_grant3", 64'(grant), 64'd3);
    cack = 1'b1;
    tick();
    cack = 1'b0;
    req[3] = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wack = 1'b1;
      tick();
      wack = 1'b0;
    end
    chk("rs_midburst", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_cmdreq", 64'(s_cmd_req), 64'd0);
    chk("rs_busy", 64'(busy), 64'd0);
    chk("rs_grant", 64'(grant), 64'd5);
    chk("rs_stray", 64'(stray_err), 64'd0);
    #3;
    rst_n = 1'b1;
    req = 6'b001001;
    tick();
    chk("rs_first", 64'(grant), 64'd0);
    chk("rs_first_req", 64'(s_cmd_req), 64'd1);
    req = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
